// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: formats stores, runs req/gnt/rvalid to data memory, extracts loads.
// Latency: non-memory ops and checked-out faults respond 1 cycle after accept; memory ops take gnt + rvalid wait.
// Backpressure: ex_ready is low while a memory access is outstanding in REQ or RESP; a bounded timeout aborts it.
module mem_stage_lsu #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [4:0]  rd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // Counter only needs to reach BUS_TIMEOUT-1; abort fires on the edge that would complete the last cycle.
    localparam int            CW       = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(BUS_TIMEOUT - 1);
    localparam bit            TMO_EN   = (BUS_TIMEOUT != 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          exc_valid_q, exc_valid_d;
    logic [1:0]    exc_cause_q, exc_cause_d;
    logic [31:0]   exc_addr_q, exc_addr_d;

    logic          is_mem;
    logic          chk_illegal;
    logic          chk_misalign;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic [31:0]   ld_shifted;
    logic [31:0]   ld_value;

    // Decode the EX-stage op: legality checks and store lane formatting, ready for capture at accept.
    always_comb begin
        is_mem       = is_load | is_store;
        chk_illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
        chk_misalign = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                       ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << {alu_out[1], 1'b0};
            end
            default: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            st_wstrb = 4'b0000;
        end
    end

    // Bring the addressed byte/half to bit 0 and extend according to the captured width/sign.
    always_comb begin
        ld_shifted = dm_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_value = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_value = {16'd0, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

    // Next-state: IDLE accepts/answers ops, REQ waits for grant, RESP waits for load data; both bounded by timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_data_d  = (rd == 5'd0) ? 32'd0 : alu_out;
                    end else if (chk_illegal) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CAUSE_ILLEGAL;
                        exc_addr_d  = alu_out;
                    end else if (chk_misalign) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CAUSE_MISALIGN;
                        exc_addr_d  = alu_out;
                    end else begin
                        addr_d  = alu_out;
                        f3_d    = funct3;
                        rd_d    = rd;
                        we_d    = is_store;
                        wdata_d = st_wdata;
                        wstrb_d = st_wstrb;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dm_gnt) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = we_q ? S_IDLE : S_RESP;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    req_d       = 1'b0;
                    exc_valid_d = 1'b1;
                    exc_cause_d = CAUSE_TIMEOUT;
                    exc_addr_d  = addr_q;
                    state_d     = S_IDLE;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (dm_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = (rd_q == 5'd0) ? 32'd0 : ld_value;
                    state_d    = S_IDLE;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    exc_valid_d = 1'b1;
                    exc_cause_d = CAUSE_TIMEOUT;
                    exc_addr_d  = addr_q;
                    state_d     = S_IDLE;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset kills any in-flight request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            f3_q        <= 3'd0;
            rd_q        <= 5'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign ex_ready  = (state_q == S_IDLE);
    assign dm_req    = req_q;
    assign dm_we     = we_q;
    assign dm_addr   = {addr_q[31:2], 2'b00};
    assign dm_wstrb  = wstrb_q;
    assign dm_wdata  = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit in the MEM stage, directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address (or as the pass-through result for non-memory ops) and runs a request/grant/response handshake to the data memory.
- Aligns store data and builds byte strobes; extracts and sign/zero-extends load data.
- Delivers a single-cycle writeback pulse, or an exception pulse for misaligned, illegal or timed-out accesses.

Parameters:
- BUS_TIMEOUT, 255: max cycles spent in REQ or RESP before abort with bus-error exception; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX stage presents an op this cycle.
- ex_ready  out  1  combinational, = (state==IDLE).
- alu_out  in  32  ALU result: effective address for loads/stores, result otherwise.
- store_data  in  32  rs2 value for stores.
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- is_load  in  1  op is a load.
- is_store  in  1  op is a store; is_load and is_store are never both 1.
- rd  in  5  destination register.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word address = {addr[31:2],2'b00}.
- dm_wstrb  out  4  byte write strobes; 0 for loads.
- dm_wdata  out  32  lane-replicated store data.
- dm_gnt  in  1  memory accepts request.
- dm_rvalid  in  1  load data valid.
- dm_rdata  in  32  load data word.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  01 misaligned, 10 illegal width, 11 bus timeout.
- exc_addr  out  32  faulting effective address.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, except ex_ready=1; timeout counter 0.
- dm_req drops immediately on reset, including mid-transaction; an outstanding rvalid after reset is ignored.
- Accept: an op is accepted on a rising edge where ex_valid && ex_ready.
- States:
  - IDLE: non-memory op -> wb_valid=1, wb_rd=rd, wb_data=alu_out next cycle (latency 1); stay IDLE.
  - IDLE: memory op whose checks fail -> exc_valid pulse next cycle, exc_addr=alu_out; no memory access, no wb; stay IDLE.
  - IDLE: legal memory op -> capture addr/funct3/rd/data; dm_req=1 next cycle; go to REQ.
  - REQ: dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata held stable until the cycle with dm_gnt=1. On that edge dm_req goes to 0. Store -> IDLE (no wb pulse). Load -> RESP.
  - RESP: wait for dm_rvalid. dm_rvalid is only sampled in RESP. On the edge it is seen: wb_valid=1 next cycle, wb_data=extracted load value; go to IDLE.
- Checks (applied in priority order at accept):
  - funct3 in {011,110,111}, or a store with funct3 in {100,101} -> cause 10.
  - H/HU with addr[0]=1, or W with addr[1:0]!=0 -> cause 01.
- Store formatting:
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=0011<<{addr[1],1'b0}.
  - SW: wdata=sd, wstrb=1111.
- Load extraction: shift dm_rdata right by 8*addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- rd=0: wb_valid still pulses; wb_data forced to 0.
- Timeout: counter clears on entering REQ and on entering RESP, and increments each cycle in those states. When it reaches BUS_TIMEOUT: drop dm_req, exc_valid pulse with cause 11 and exc_addr = captured address, go to IDLE.
- ex_ready is 1 in the same cycle wb_valid/exc_valid pulses (state already IDLE), so back-to-back ops are allowed.
- wb_valid and exc_valid are never both 1.
- wb_rd, wb_data and exc_* hold their last values when their valid is 0.

Test Plan:
- Non-memory op: alu_out=0x0000_1234, rd=5 -> one cycle later wb_valid=1, wb_rd=5, wb_data=0x0000_1234; no dm_req.
- SB with addr=0x1003, store_data=0xAABBCCDD, gnt one cycle after req -> dm_addr=0x1000, dm_wstrb=1000, dm_wdata=0xDDDDDDDD, dm_we=1; no wb_valid; ex_ready returns the cycle after gnt.
- LH with addr=0x2002, gnt after 2 cycles of wait, rvalid 3 cycles later with rdata=0x8001_0000 -> wb_data=0xFFFF_8001. Same sequence as LHU -> wb_data=0x0000_8001.
- LW with addr=0x3001 -> exc_valid, cause 01, exc_addr=0x3001; no dm_req. Load with funct3=011 -> cause 10.
- BUS_TIMEOUT=4, load with dm_gnt held 0 -> dm_req high 4 cycles, then drops; exc cause 11 with exc_addr = captured address.
- Assert rst_n=0 while in RESP -> dm_req, wb_valid and exc_valid all 0 immediately; a late rvalid produces no wb_valid; ex_ready=1 after reset.
